// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard sequencer.
// The datapath (master) supplies the hazard sources; the sequencer (slave) returns
// the stage enables, the flush strobes and the statistics.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             usesRt_ID;
  logic             memRead_EXE;
  logic [4:0]       regWriteAddress_EXE;
  logic             jumpTaken_EXE;
  logic             branchTaken_MEM;
  logic             memBusy_MEM;

  logic             PCWrite;
  logic             IFtoID_write;
  logic             pipeEnable;
  logic             IFtoID_flush;
  logic             IDtoEXE_flush;
  logic             EXEtoMEM_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;
  logic             freezeTimeout;

  modport master (
    output rs_ID, rt_ID, usesRt_ID, memRead_EXE, regWriteAddress_EXE,
           jumpTaken_EXE, branchTaken_MEM, memBusy_MEM,
    input  PCWrite, IFtoID_write, pipeEnable, IFtoID_flush, IDtoEXE_flush,
           EXEtoMEM_flush, state, stallCount, flushCount, freezeTimeout
  );

  modport slave (
    input  rs_ID, rt_ID, usesRt_ID, memRead_EXE, regWriteAddress_EXE,
           jumpTaken_EXE, branchTaken_MEM, memBusy_MEM,
    output PCWrite, IFtoID_write, pipeEnable, IFtoID_flush, IDtoEXE_flush,
           EXEtoMEM_flush, state, stallCount, flushCount, freezeTimeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
//
//   state  | meaning
//   INIT   | post-reset window: PC held, every pipeline register loads a bubble
//   RUN    | normal issue; load-use stall, jump/branch flush, or freeze on memBusy
//   FREEZE | data RAM busy: everything held; leaves as soon as memBusy_MEM drops
//
// In FREEZE with memBusy_MEM low the cycle is evaluated exactly like RUN, so a
// branch or jump that was waiting behind the busy RAM flushes in that same cycle.
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MAX_FREEZE  = 15,
  parameter int CNT_W       = 32
) (
  input  logic CLK,
  input  logic Reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int FRZ_W  = (MAX_FREEZE > 0) ? $clog2(MAX_FREEZE + 1) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [FRZ_W-1:0]  FRZ_LIMIT = FRZ_W'(MAX_FREEZE);
  localparam logic [FRZ_W-1:0]  FRZ_LAST  = FRZ_W'(MAX_FREEZE - 1);

  state_t             stateQ, stateD;
  logic [INIT_W-1:0]  initCnt;
  logic [FRZ_W-1:0]   freezeCnt;
  logic [CNT_W-1:0]   stallCnt;
  logic [CNT_W-1:0]   flushCnt;
  logic               timeoutQ;

  logic loadUse;
  logic stallEv;
  logic flushEv;
  logic pcWrite, ifIdWrite, pipeEn, ifIdFlush, idExFlush, exMemFlush;

  // A register of 0 is never a real dependency, so it cannot cause a stall.
  assign loadUse = bus.memRead_EXE && (bus.regWriteAddress_EXE != 5'd0) &&
                   ((bus.regWriteAddress_EXE == bus.rs_ID) ||
                    (bus.usesRt_ID && (bus.regWriteAddress_EXE == bus.rt_ID)));

  // Next state and per-cycle pipeline controls; INIT/reset values are the defaults.
  always_comb begin
    stateD     = stateQ;
    pcWrite    = 1'b0;
    ifIdWrite  = 1'b1;
    pipeEn     = 1'b1;
    ifIdFlush  = 1'b1;
    idExFlush  = 1'b1;
    exMemFlush = 1'b1;
    stallEv    = 1'b0;
    flushEv    = 1'b0;
    case (stateQ)
      INIT: begin
        if (initCnt == INIT_LAST) stateD = RUN;
      end
      RUN, FREEZE: begin
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        exMemFlush = 1'b0;
        if (bus.memBusy_MEM) begin
          ifIdWrite = 1'b0;
          pipeEn    = 1'b0;
          stateD    = FREEZE;
        end else begin
          stateD  = RUN;
          pcWrite = 1'b1;
          if (bus.branchTaken_MEM) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
            flushEv    = 1'b1;
          end else if (bus.jumpTaken_EXE) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            flushEv   = 1'b1;
          end else if (loadUse) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
            stallEv   = 1'b1;
          end
        end
      end
      default: stateD = INIT;
    endcase
  end

  // State register and INIT window counter.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stateQ  <= INIT;
      initCnt <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == INIT && initCnt != INIT_LAST) initCnt <= initCnt + 1'b1;
    end
  end

  // Freeze length watchdog; only observes, never steers the FSM.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      freezeCnt <= '0;
      timeoutQ  <= 1'b0;
    end else begin
      if (stateQ != FREEZE && stateD == FREEZE) begin
        freezeCnt <= '0;
      end else if (stateQ == FREEZE) begin
        if (freezeCnt != FRZ_LIMIT) freezeCnt <= freezeCnt + 1'b1;
        if (freezeCnt == FRZ_LAST) timeoutQ <= 1'b1;
      end
    end
  end

  // Saturating statistics; a cycle with both branch and jump is one flush event.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallEv && !(&stallCnt)) stallCnt <= stallCnt + 1'b1;
      if (flushEv && !(&flushCnt)) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign bus.PCWrite        = pcWrite;
  assign bus.IFtoID_write   = ifIdWrite;
  assign bus.pipeEnable     = pipeEn;
  assign bus.IFtoID_flush   = ifIdFlush;
  assign bus.IDtoEXE_flush  = idExFlush;
  assign bus.EXEtoMEM_flush = exMemFlush;
  assign bus.state          = stateQ;
  assign bus.stallCount     = stallCnt;
  assign bus.flushCount     = flushCnt;
  assign bus.freezeTimeout  = timeoutQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: INIT window, load-use, jump/branch
// priority, freeze and its watchdog, counter saturation and reset mid-freeze.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  // Control vector order: {PCWrite, IFtoID_write, pipeEnable, IFflush, IDflush, EXflush}
  localparam logic [5:0] C_INIT   = 6'b011111;
  localparam logic [5:0] C_RUN    = 6'b111000;
  localparam logic [5:0] C_STALL  = 6'b001010;
  localparam logic [5:0] C_JUMP   = 6'b111110;
  localparam logic [5:0] C_BRANCH = 6'b111111;
  localparam logic [5:0] C_FRZ    = 6'b000000;

  logic CLK;
  logic Reset;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipeline_hazard_ctrl #(
    .INIT_CYCLES(2),
    .MAX_FREEZE (15),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   nAsserts = 0;
  int   nFail    = 0;
  int   expStall = 0;
  int   expFlush = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic pushExp(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [7:0] obs);
    exp_t e;
    nAsserts++;
    if (sb.size() == 0) begin
      nFail++;
      $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nFail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [7:0] ctrlObs();
    return {2'b00, bus.PCWrite, bus.IFtoID_write, bus.pipeEnable,
            bus.IFtoID_flush, bus.IDtoEXE_flush, bus.EXEtoMEM_flush};
  endfunction

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                       input logic memRead, input logic [4:0] wa, input logic jump,
                       input logic branch, input logic busy);
    bus.rs_ID               = rs;
    bus.rt_ID               = rt;
    bus.usesRt_ID           = usesRt;
    bus.memRead_EXE         = memRead;
    bus.regWriteAddress_EXE = wa;
    bus.jumpTaken_EXE       = jump;
    bus.branchTaken_MEM     = branch;
    bus.memBusy_MEM         = busy;
  endtask

  // Expected results are queued with the stimulus; controls are checked inside the
  // cycle, registered results just after the rising edge.
  task automatic cyc(input string tag, input logic [5:0] eCtrl, input logic [1:0] eState,
                     input bit stallEv, input bit flushEv, input bit eTo);
    if (stallEv) expStall = (expStall == SAT) ? SAT : expStall + 1;
    if (flushEv) expFlush = (expFlush == SAT) ? SAT : expFlush + 1;
    pushExp({tag, "_ctrl"}, {2'b00, eCtrl});
    pushExp({tag, "_state"}, {6'b0, eState});
    pushExp({tag, "_stallCount"}, 8'(expStall));
    pushExp({tag, "_flushCount"}, 8'(expFlush));
    pushExp({tag, "_timeout"}, {7'b0, eTo});
    #1;
    popCheck(ctrlObs());
    @(posedge CLK);
    #1;
    popCheck({6'b0, bus.state});
    popCheck({4'b0, bus.stallCount});
    popCheck({4'b0, bus.flushCount});
    popCheck({7'b0, bus.freezeTimeout});
    @(negedge CLK);
  endtask

  task automatic checkResetState(input string tag);
    pushExp({tag, "_ctrl"}, {2'b00, C_INIT});
    pushExp({tag, "_state"}, 8'd0);
    pushExp({tag, "_stallCount"}, 8'd0);
    pushExp({tag, "_flushCount"}, 8'd0);
    pushExp({tag, "_timeout"}, 8'd0);
    #1;
    popCheck(ctrlObs());
    popCheck({6'b0, bus.state});
    popCheck({4'b0, bus.stallCount});
    popCheck({4'b0, bus.flushCount});
    popCheck({7'b0, bus.freezeTimeout});
  endtask

  initial begin
    Reset = 1'b0;
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    checkResetState("reset");

    // INIT window: two held cycles, RUN after the second edge
    Reset = 1'b1;
    cyc("initA", C_INIT, 2'd0, 0, 0, 0);
    cyc("initB", C_INIT, 2'd1, 0, 0, 0);
    cyc("idle",  C_RUN,  2'd1, 0, 0, 0);

    // load-use via rs, then the same with destination $0
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("luRs", C_STALL, 2'd1, 1, 0, 0);
    setIn(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("luZero", C_RUN, 2'd1, 0, 0, 0);
    // rt dependency only counts when rt is actually read
    setIn(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("luRt", C_STALL, 2'd1, 1, 0, 0);
    setIn(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cyc("luRtUnused", C_RUN, 2'd1, 0, 0, 0);
    // not a load: no stall even with matching registers
    setIn(5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc("noLoad", C_RUN, 2'd1, 0, 0, 0);

    // jump, branch over jump and load-use, jump over load-use
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("jump", C_JUMP, 2'd1, 0, 1, 0);
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc("branchAll", C_BRANCH, 2'd1, 0, 1, 0);
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("jumpOverLu", C_JUMP, 2'd1, 0, 1, 0);

    // branch held behind a 3-cycle busy RAM, flushed when busy drops
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("busyBr1", C_FRZ, 2'd2, 0, 0, 0);
    cyc("busyBr2", C_FRZ, 2'd2, 0, 0, 0);
    cyc("busyBr3", C_FRZ, 2'd2, 0, 0, 0);
    bus.memBusy_MEM = 1'b0;
    cyc("busyBrExit", C_BRANCH, 2'd1, 0, 1, 0);

    // 20 busy cycles: 1 RUN + 19 FREEZE; watchdog fires at the 15th FREEZE cycle
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cyc("busy20", C_FRZ, 2'd2, 0, 0, (k >= 16));
    end
    // leaving FREEZE evaluates as RUN, including a load-use stall
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("frzExitStall", C_STALL, 2'd1, 1, 0, 1);
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("timeoutSticky", C_RUN, 2'd1, 0, 0, 1);

    // saturation of both 4-bit counters
    setIn(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cyc("stallSat", C_STALL, 2'd1, 1, 0, 1);
    end
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cyc("flushSat", C_JUMP, 2'd1, 0, 1, 1);
    end

    // reset pulsed in the middle of a freeze
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("frzA", C_FRZ, 2'd2, 0, 0, 1);
    cyc("frzB", C_FRZ, 2'd2, 0, 0, 1);
    Reset    = 1'b0;
    expStall = 0;
    expFlush = 0;
    checkResetState("resetMidFreeze");
    @(negedge CLK);
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    cyc("reinitA", C_INIT, 2'd0, 0, 0, 0);
    cyc("reinitB", C_INIT, 2'd1, 0, 0, 0);
    cyc("reidle",  C_RUN,  2'd1, 0, 0, 0);

    if (sb.size() != 0) begin
      nAsserts++;
      nFail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline (IF, ID, EXE, MEM, WB). It detects load-use hazards in ID against a load in EXE, and flushes wrong-path instructions on a jump resolved in EXE or a branch taken in MEM. It freezes the whole pipeline while the data RAM reports busy and holds the PC through a post-reset initialisation window. It drives the PC write enable and the per-stage write/flush controls of the pipeline registers, and keeps saturating stall/flush statistics counters.

## Interface
Parameters:
- INIT_CYCLES, 2, cycles after reset release during which PC is held and all stages flushed (≥1)
- MAX_FREEZE, 15, consecutive FREEZE cycles after which freezeTimeout is set
- CNT_W, 32, width of statistics counters

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- rs_ID  in  5  source register 1 of instruction in ID
- rt_ID  in  5  source register 2 of instruction in ID
- usesRt_ID  in  1  instruction in ID reads rt_ID (R-type, store, branch)
- memRead_EXE  in  1  instruction in EXE is a load
- regWriteAddress_EXE  in  5  destination of instruction in EXE
- jumpTaken_EXE  in  1  jump resolved in EXE this cycle
- branchTaken_MEM  in  1  branch taken, resolved in MEM this cycle
- memBusy_MEM  in  1  data RAM cannot complete the access this cycle
- PCWrite  out  1  PC update enable
- IFtoID_write  out  1  IF/ID register enable
- pipeEnable  out  1  enable for ID/EXE, EXE/MEM and MEM/WB registers
- IFtoID_flush, IDtoEXE_flush, EXEtoMEM_flush  out  1 each  load a bubble (all controls zero) into that register
- state  out  2  INIT=0, RUN=1, FREEZE=2
- stallCount, flushCount  out  CNT_W  saturating event counters
- freezeTimeout  out  1  sticky, set when the freeze limit is reached

## Operation
- Load-use hazard (RUN only): hazard = memRead_EXE & regWriteAddress_EXE≠0 & (regWriteAddress_EXE==rs_ID | (usesRt_ID & regWriteAddress_EXE==rt_ID)). Response: PCWrite=0, IFtoID_write=0, IDtoEXE_flush=1 for one cycle. The bubble then removes the hazard. MEM/WB forwarding covers all remaining cases.
- Jump (RUN): IFtoID_flush=1, IDtoEXE_flush=1, PCWrite=1.
- Branch taken (RUN): IFtoID_flush=1, IDtoEXE_flush=1, EXEtoMEM_flush=1, PCWrite=1.
- Priority in RUN: memBusy_MEM > branchTaken_MEM > jumpTaken_EXE > load-use. A lower-priority action is fully suppressed. A branch kills the jump and the dependent instruction.
- Default in RUN with no event: PCWrite=1, IFtoID_write=1, pipeEnable=1, all flushes 0.
- FSM:
  - INIT: PCWrite=0, IFtoID_write=1, pipeEnable=1, all flushes=1. Counts INIT_CYCLES cycles, then goes to RUN.
  - RUN with memBusy_MEM=1: that cycle PCWrite=0, IFtoID_write=0, pipeEnable=0, flushes 0. Next state FREEZE.
  - FREEZE with memBusy_MEM=1: same freeze outputs, stay in FREEZE.
  - FREEZE with memBusy_MEM=0: evaluate as RUN this cycle, including branch, jump and load-use. Next state RUN.
- Freeze counter: clears on entry to FREEZE, increments each FREEZE cycle, saturates. freezeTimeout←1 when the count reaches MAX_FREEZE. It is cleared only by Reset. The FSM is unaffected.
- stallCount +1 per load-use stall cycle. flushCount +1 per cycle with a branch or jump flush (one event even if both are pending). Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Hazard, flush and freeze outputs are combinational from inputs and registered state, valid in the same cycle the condition is present.
- State, INIT counter, freeze counter, statistics counters and freezeTimeout update on the rising CLK edge.
- Reset low (asynchronous): state=INIT, INIT counter=0, freeze counter=0, stallCount=0, flushCount=0, freezeTimeout=0. Outputs during reset: PCWrite=0, IFtoID_write=1, pipeEnable=1, all flushes=1.
- First RUN cycle is the (INIT_CYCLES+1)th rising edge after Reset goes high.
- Reset asserted mid-FREEZE or mid-stall forces INIT immediately. Reset does not wait for memBusy_MEM.
- Load-use costs exactly 1 cycle. Jump costs 2 flushed slots. Branch costs 3 flushed slots.

## Test plan
- Reset release, INIT_CYCLES=2 -> PCWrite=0 and all flushes=1 for 2 cycles; state=1 on the 3rd edge; all counters 0.
- lw writes $5 in EXE (memRead_EXE=1, regWriteAddress_EXE=5), ID has rs_ID=5 -> one cycle of PCWrite=0, IFtoID_write=0, IDtoEXE_flush=1; stallCount=1. Same stimulus with destination 0 -> no stall.
- branchTaken_MEM=1 together with a load-use hazard and jumpTaken_EXE=1 -> all three flushes=1, PCWrite=1, no stall; flushCount+1, stallCount unchanged.
- memBusy_MEM held 3 cycles during a branch -> pipeEnable=0 and no flush for 3 cycles; branch flush issued in the cycle memBusy_MEM drops; state 2→1.
- memBusy_MEM held 20 cycles, MAX_FREEZE=15 -> freezeTimeout=1 after the 15th FREEZE cycle; stays 1 after memBusy drops, until Reset.
- CNT_W=4 with 17 load-use events -> stallCount saturates at 15. Reset pulsed mid-FREEZE -> state=0 immediately, counters 0.
